// File: rtl/hex_score_display.sv
// hex_score_display: binary-to-BCD (sequential double-dabble) driver for a bank
// of active-low 7-segment HEX displays. One conversion step per clock; the
// display and overflow flag change only at commit, never mid-conversion.
// Optional feature macro: HEX_SCORE_LEADING_BLANK_EN (blank leading zero digits).
module hex_score_display #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Largest value that fits in DIGITS decimal digits.
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    localparam logic [31:0] MAX_VAL = pow10(DIGITS) - 32'd1;

    // Active-low segment pattern (g..a) for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // Pattern shown after reset: "0" in digit 0; upper digits blank or "0".
    function automatic logic [7*DIGITS-1:0] reset_pattern();
        logic [7*DIGITS-1:0] p;
        for (int k = 0; k < DIGITS; k++) begin
`ifdef HEX_SCORE_LEADING_BLANK_EN
            p[7*k +: 7] = (k == 0) ? SEG_ZERO : SEG_BLANK;
`else
            p[7*k +: 7] = SEG_ZERO;
`endif
        end
        return p;
    endfunction

    localparam logic [7*DIGITS-1:0] HEX_RESET = reset_pattern();
    localparam logic [7*DIGITS-1:0] HEX_DASH  = {DIGITS{SEG_DASH}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [7*DIGITS-1:0]  hex_q, hex_d;
    logic                 ovf_q, ovf_d;

    logic                 last_step;
    logic [BW-1:0]        bcd_adj;
    logic [BW+WIDTH-1:0]  step_shift;
    logic [BW-1:0]        bcd_step;
    logic [WIDTH-1:0]     bin_step;
    logic [7*DIGITS-1:0]  disp_val;

    assign last_step = (count_q == CW'(WIDTH - 1));

    // Add-3 correction on every nibble that is 5 or more, ahead of the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                        (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
        end
    endgenerate

    // Shift the combined {bcd, bin} left; anything leaving the top nibble is lost.
    assign step_shift = {bcd_adj, bin_q} << 1;
    assign bcd_step   = step_shift[BW+WIDTH-1:WIDTH];
    assign bin_step   = step_shift[WIDTH-1:0];

    // Display image built from the result of the final step, so it can be
    // registered on the same edge that enters COMMIT.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_disp
`ifdef HEX_SCORE_LEADING_BLANK_EN
            if (gi == 0) begin : g_lsd
                assign disp_val[6:0] = seg7(bcd_step[3:0]);
            end else begin : g_upper
                assign disp_val[7*gi +: 7] = (bcd_step[BW-1:4*gi] == '0) ?
                                             SEG_BLANK : seg7(bcd_step[4*gi +: 4]);
            end
`else
            assign disp_val[7*gi +: 7] = seg7(bcd_step[4*gi +: 4]);
`endif
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SHIFT;
            S_SHIFT:  if (last_step) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: load on accept, step while shifting, publish on last step.
    always_comb begin
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        count_d    = count_q;
        ovf_pend_d = ovf_pend_q;
        hex_d      = hex_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d      = value;
                    bcd_d      = '0;
                    count_d    = '0;
                    ovf_pend_d = (32'(value) > MAX_VAL);
                end
            end
            S_SHIFT: begin
                bin_d   = bin_step;
                bcd_d   = bcd_step;
                count_d = count_q + CW'(1);
                if (last_step) begin
                    hex_d = ovf_pend_q ? HEX_DASH : disp_val;
                    ovf_d = ovf_pend_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            hex_q      <= HEX_RESET;
            ovf_q      <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            count_q    <= count_d;
            ovf_pend_q <= ovf_pend_d;
            hex_q      <= hex_d;
            ovf_q      <= ovf_d;
        end
    end

    // Outputs: status decoded from state, display straight from registers.
    always_comb begin
        busy     = (state_q == S_SHIFT);
        done     = (state_q == S_COMMIT);
        hex_out  = hex_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_hex_score_display.sv
// Testbench for hex_score_display (default WIDTH=10, DIGITS=3): directed
// boundary cases plus randomized conversions against a decimal-arithmetic model.
module tb_hex_score_display;

    localparam int W = 10;
    localparam int D = 3;

`ifdef HEX_SCORE_LEADING_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   value;
    logic           busy;
    logic           done;
    logic           overflow;
    logic [7*D-1:0] hex_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7*D-1:0] exp_hex;
    logic           exp_ovf;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0011000};

    hex_score_display #(.WIDTH(W), .DIGITS(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hex_out  (hex_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected display for a value, straight from decimal arithmetic.
    function automatic logic [7*D-1:0] model_hex(input int v);
        logic [7*D-1:0] r;
        int lim = 1;
        int p   = 1;
        for (int k = 0; k < D; k++) lim = lim * 10;
        for (int k = 0; k < D; k++) begin
            if (v >= lim)
                r[7*k +: 7] = 7'b0111111;
            else if (BLANK_EN && k > 0 && v < p)
                r[7*k +: 7] = 7'b1111111;
            else
                r[7*k +: 7] = seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    function automatic bit model_ovf(input int v);
        int lim = 1;
        for (int k = 0; k < D; k++) lim = lim * 10;
        return (v >= lim);
    endfunction

    // One conversion; optional extra start (gk>0) at cycle gk must be ignored.
    task automatic run_conv(input int v, input int gk, input int gv);
        int done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        value = W'(v);
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (k == 1) check_eq("busy_first", busy, 1'b1);
            if (k == W) begin
                check_eq("busy_last", busy, 1'b1);
                check_eq("done_early", done, 1'b0);
                check_eq("hex_hold", hex_out, exp_hex);
                check_eq("ovf_hold", overflow, exp_ovf);
            end
            if (k == W + 1) begin
                exp_hex = model_hex(v);
                exp_ovf = model_ovf(v);
                check_eq("done_pulse", done, 1'b1);
                check_eq("busy_commit", busy, 1'b0);
                check_eq("hex_commit", hex_out, exp_hex);
                check_eq("ovf_commit", overflow, exp_ovf);
            end
            if (k == W + 2) begin
                check_eq("done_clear", done, 1'b0);
                check_eq("busy_idle", busy, 1'b0);
            end
            start = (k == gk);
            if (k == gk) value = W'(gv);
        end
        start = 1'b0;
        check_eq("done_count", done_cnt, 1);
        $display("conv value=%0d extra_start_cycle=%0d hex=%h ovf=%0b", v, gk, hex_out, overflow);
    endtask

    // Start a conversion, then reset it at cycle rk; it must vanish without a trace.
    task automatic run_abort(input int v, input int rk);
        int done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        value = W'(v);
        for (int k = 1; k <= rk; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hex = model_hex(0);
        exp_ovf = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_ovf", overflow, 1'b0);
        check_eq("abort_hex", hex_out, exp_hex);
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 0);
        $display("abort value=%0d reset_cycle=%0d hex=%h", v, rk, hex_out);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_hex = model_hex(0);
        exp_ovf = 1'b0;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_hex", hex_out, exp_hex);
        $display("reset hex=%h", hex_out);

        run_conv(255, 0, 0);
        run_conv(1000, 0, 0);
        run_conv(999, 0, 0);
        run_conv(0, 0, 0);
        run_conv(7, 0, 0);
        run_conv(1023, 0, 0);
        run_conv(42, 3, 7);
        run_conv(500, W + 1, 3);
        run_abort(500, 4);
        run_conv(9, 0, 0);

        for (int i = 0; i < 30; i++) begin
            int v;
            int gk;
            v  = int'($urandom_range(0, (1 << W) - 1));
            gk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, W + 1)) : 0;
            run_conv(v, gk, int'($urandom_range(0, (1 << W) - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
